// File: rtl/slt_serial_16bit.sv
// slt_serial_16bit
// Bit-serial magnitude comparator that walks the operands from the MSB
// down to the LSB. It reports less-than, greater-than or equal through a
// START/DONE handshake. SIGNED selects a two's-complement or an unsigned
// compare. EARLY_EXIT selects variable latency, where the scan stops at the
// first differing bit, or a fixed latency of WIDTH scan cycles.

module slt_serial_16bit #(
    parameter int WIDTH      = 16,
    parameter int SIGNED     = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] LT_O,
    output logic             GT_O,
    output logic             EQ_O
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic [IW-1:0]   r_idx;
    logic            r_decided;
    logic            r_ltFlag;
    logic            r_gtFlag;

    logic w_rsBit;
    logic w_rtBit;
    logic w_differ;
    logic w_isMsb;
    logic w_invert;
    logic w_bitLt;
    logic w_bitGt;
    logic w_last;
    logic w_finish;
    logic w_finalLt;
    logic w_finalGt;

    // Per-cycle decision for the bit under the index. The sign bit of a signed compare has inverted sense.
    always_comb begin
        w_rsBit   = r_rs[r_idx];
        w_rtBit   = r_rt[r_idx];
        w_differ  = w_rsBit ^ w_rtBit;
        w_isMsb   = (r_idx == IW'(WIDTH - 1));
        w_invert  = (SIGNED != 0) && w_isMsb;
        w_bitGt   = w_differ & (w_rsBit ^ w_invert);
        w_bitLt   = w_differ & ~(w_rsBit ^ w_invert);
        w_last    = (r_idx == '0);
        w_finish  = (EARLY_EXIT != 0) ? (w_differ | w_last) : w_last;
        w_finalLt = r_decided ? r_ltFlag : w_bitLt;
        w_finalGt = r_decided ? r_gtFlag : w_bitGt;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rs      <= '0;
            r_rt      <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_ltFlag  <= 1'b0;
            r_gtFlag  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            LT_O      <= '0;
            GT_O      <= 1'b0;
            EQ_O      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        r_rs      <= RS;
                        r_rt      <= RT;
                        r_idx     <= IW'(WIDTH - 1);
                        r_decided <= 1'b0;
                        r_ltFlag  <= 1'b0;
                        r_gtFlag  <= 1'b0;
                        BUSY      <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_differ && !r_decided) begin
                        r_decided <= 1'b1;
                        r_ltFlag  <= w_bitLt;
                        r_gtFlag  <= w_bitGt;
                    end
                    if (w_finish) begin
                        DONE    <= 1'b1;
                        LT_O    <= WIDTH'(w_finalLt);
                        GT_O    <= w_finalGt;
                        EQ_O    <= ~(w_finalLt | w_finalGt);
                        r_state <= S_RESP;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_RESP: begin
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slt_serial_16bit.sv
// tb_slt_serial_16bit
// The bench drives three comparator instances from shared inputs:
// signed/early-exit, unsigned/early-exit and signed/fixed-latency.
// A table of vectors with hand-computed expected values checks each
// instance. Hand-written sequences cover START held high and a reset in
// the middle of a compare.

module tb_slt_serial_16bit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] RS;
    logic [15:0] RT;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  gt;
    logic [2:0]  eq;
    logic [15:0] lt [3];

    int checks = 0;
    int passes = 0;

    int          firstDone [3];
    int          doneCnt   [3];
    logic [15:0] resLt     [3];
    logic        resGt     [3];
    logic        resEq     [3];

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic        sLt, sGt, sEq;
        logic        uLt, uGt, uEq;
        int          nEarly;
    } vec_t;

    vec_t vecs [12];

    // Free-running clock with a 10 time-unit period.
    always #5 CLK = ~CLK;

    slt_serial_16bit #(.WIDTH(16), .SIGNED(1), .EARLY_EXIT(1)) u_s1e1 (
        .CLK(CLK), .RST(RST), .START(START), .RS(RS), .RT(RT),
        .BUSY(busy[0]), .DONE(done[0]), .LT_O(lt[0]), .GT_O(gt[0]), .EQ_O(eq[0])
    );

    slt_serial_16bit #(.WIDTH(16), .SIGNED(0), .EARLY_EXIT(1)) u_s0e1 (
        .CLK(CLK), .RST(RST), .START(START), .RS(RS), .RT(RT),
        .BUSY(busy[1]), .DONE(done[1]), .LT_O(lt[1]), .GT_O(gt[1]), .EQ_O(eq[1])
    );

    slt_serial_16bit #(.WIDTH(16), .SIGNED(1), .EARLY_EXIT(0)) u_s1e0 (
        .CLK(CLK), .RST(RST), .START(START), .RS(RS), .RT(RT),
        .BUSY(busy[2]), .DONE(done[2]), .LT_O(lt[2]), .GT_O(gt[2]), .EQ_O(eq[2])
    );

    // Single comparison point that counts checks and passes.
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Pulses START for one cycle, then watches a fixed 20-cycle window and records each DONE.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        RS = a;
        RT = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            firstDone[k] = -1;
            doneCnt[k]   = 0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    doneCnt[k]++;
                    if (firstDone[k] < 0) begin
                        firstDone[k] = c;
                        resLt[k] = lt[k];
                        resGt[k] = gt[k];
                        resEq[k] = eq[k];
                    end
                end
            end
        end
    endtask

    // Compares the recorded DONE timing and results of one instance.
    task automatic checkOutput(input string tag, input int k, input int lat,
                               input logic eLt, input logic eGt, input logic eEq);
        check($sformatf("%s dut%0d doneCount", tag, k), doneCnt[k], 1);
        check($sformatf("%s dut%0d latency", tag, k), firstDone[k], lat);
        check($sformatf("%s dut%0d LT_O", tag, k), int'(resLt[k]), eLt ? 1 : 0);
        check($sformatf("%s dut%0d GT_O", tag, k), int'(resGt[k]), int'(eGt));
        check($sformatf("%s dut%0d EQ_O", tag, k), int'(resEq[k]), int'(eEq));
    endtask

    initial begin
        int holdDone [3];
        int holdCnt  [3];
        int busyLow  [3];
        logic [15:0] holdLt [3][2];
        logic        holdGt [3][2];

        //          rs        rt        sLt   sGt   sEq   uLt   uGt   uEq   n
        vecs[0]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16};
        vecs[4]  = '{16'h0004, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[5]  = '{16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{16'h1234, 16'h1244, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10};
        vecs[8]  = '{16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[9]  = '{16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16};
        vecs[11] = '{16'h8001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16};

        RST = 1'b1;
        START = 1'b0;
        RS = '0;
        RT = '0;
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset dut%0d BUSY", k), int'(busy[k]), 0);
            check($sformatf("reset dut%0d DONE", k), int'(done[k]), 0);
            check($sformatf("reset dut%0d LT_O", k), int'(lt[k]), 0);
            check($sformatf("reset dut%0d GT_O", k), int'(gt[k]), 0);
            check($sformatf("reset dut%0d EQ_O", k), int'(eq[k]), 0);
        end
        @(negedge CLK);
        RST = 1'b0;

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].rs, vecs[v].rt);
            checkOutput($sformatf("v%0d", v), 0, vecs[v].nEarly, vecs[v].sLt, vecs[v].sGt, vecs[v].sEq);
            checkOutput($sformatf("v%0d", v), 1, vecs[v].nEarly, vecs[v].uLt, vecs[v].uGt, vecs[v].uEq);
            checkOutput($sformatf("v%0d", v), 2, 16, vecs[v].sLt, vecs[v].sGt, vecs[v].sEq);
        end

        // START held high. Operands are toggled while busy, so only the values captured at acceptance count.
        @(negedge CLK);
        RS = 16'h0004;
        RT = 16'h0005;
        START = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            holdCnt[k] = 0;
            busyLow[k] = 0;
            holdDone[k] = -1;
        end
        for (int c = 1; c <= 36; c++) begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    if (holdCnt[k] < 2) begin
                        holdLt[k][holdCnt[k]] = lt[k];
                        holdGt[k][holdCnt[k]] = gt[k];
                    end
                    if (holdCnt[k] == 0) holdDone[k] = c;
                    holdCnt[k]++;
                end
                if (c <= 34 && !busy[k]) busyLow[k]++;
            end
            if (c >= 16) begin
                RS = 16'h0005;
                RT = 16'h0004;
            end else if (c % 2 == 1) begin
                RS = 16'h8000;
                RT = 16'h7FFF;
            end else begin
                RS = 16'hFFFF;
                RT = 16'h0001;
            end
            if (c == 34) START = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold dut%0d doneCount", k), holdCnt[k], 2);
            check($sformatf("hold dut%0d firstDone", k), holdDone[k], 16);
            check($sformatf("hold dut%0d busyLowCycles", k), busyLow[k], 1);
            check($sformatf("hold dut%0d LT_O first", k), int'(holdLt[k][0]), 1);
            check($sformatf("hold dut%0d GT_O second", k), int'(holdGt[k][1]), 1);
            check($sformatf("hold dut%0d LT_O second", k), int'(holdLt[k][1]), 0);
        end

        // Reset in the middle of a 17-cycle compare, then a fresh compare.
        @(negedge CLK);
        RS = 16'hA5A5;
        RT = 16'hA5A5;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst dut%0d BUSY", k), int'(busy[k]), 0);
            check($sformatf("midrst dut%0d DONE", k), int'(done[k]), 0);
            check($sformatf("midrst dut%0d LT_O", k), int'(lt[k]), 0);
            check($sformatf("midrst dut%0d GT_O", k), int'(gt[k]), 0);
            check($sformatf("midrst dut%0d EQ_O", k), int'(eq[k]), 0);
            doneCnt[k] = 0;
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 3; k++) if (done[k]) doneCnt[k]++;
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("midrst dut%0d strayDone", k), doneCnt[k], 0);

        applyStimulus(16'hFFFF, 16'h0000);
        checkOutput("postrst", 0, 1, 1'b1, 1'b0, 1'b0);
        checkOutput("postrst", 1, 1, 1'b0, 1'b1, 1'b0);
        checkOutput("postrst", 2, 16, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
